// File: rtl/uart_tx_sched_if.sv
// Bundles the requester-side streams and the uart_tx-side byte handshake of
// the packet scheduler. The master modport is the scheduler's view.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 2
) ();
  localparam int GW = $clog2(NUM_REQ);

  logic [8*NUM_REQ-1:0] in_data;
  logic [NUM_REQ-1:0]   in_valid;
  logic [NUM_REQ-1:0]   in_last;
  logic [NUM_REQ-1:0]   in_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic [GW-1:0]        grant;

  modport master (
    input  in_data, in_valid, in_last, tx_ready,
    output in_ready, tx_data, tx_valid, busy, grant
  );

  modport slave (
    output in_data, in_valid, in_last, tx_ready,
    input  in_ready, tx_data, tx_valid, busy, grant
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler in front of a single uart_tx byte transmitter.
// Each packet goes out as SOF, source ID, payload bytes, XOR checksum.
module uart_tx_sched #(
  parameter int         NUM_REQ  = 2,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input logic            clk,
  input logic            rstn,
  uart_tx_sched_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ID, S_PAYLOAD, S_CSUM} state_t;

  state_t               r_state, w_next_state;
  logic [GW-1:0]        r_grant, r_last_grant, w_winner;
  logic [7:0]           r_csum, r_tx_data, w_load_byte, w_sel_data;
  logic                 r_tx_valid;
  logic                 w_slot_free, w_any_valid, w_found;
  logic                 w_sel_valid, w_sel_last, w_up_xfer, w_load;
  logic [NUM_REQ-1:0]   w_in_ready;

  assign w_slot_free = !r_tx_valid || bus.tx_ready;
  assign w_any_valid = |bus.in_valid;

  // Round-robin pick: first valid requester scanning from last_grant+1
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && bus.in_valid[i] &&
            ((32'(r_last_grant) + k) % NUM_REQ) == i) begin
          w_found  = 1'b1;
          w_winner = GW'(i);
        end
      end
    end
  end

  // Select the granted requester's stream and form its ready
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_in_ready  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_sel_data    = bus.in_data[8*i +: 8];
        w_sel_valid   = bus.in_valid[i];
        w_sel_last    = bus.in_last[i];
        w_in_ready[i] = (r_state == S_PAYLOAD) && w_slot_free;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: state names the next byte to load
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_any_valid && w_slot_free) w_next_state = S_ID;
      S_ID:      if (w_slot_free) w_next_state = S_PAYLOAD;
      S_PAYLOAD: if (w_up_xfer && w_sel_last) w_next_state = S_CSUM;
      S_CSUM:    if (w_slot_free) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: candidate byte for the output register, taken when slot_free
  always_comb begin
    w_load      = 1'b0;
    w_load_byte = r_tx_data;
    w_up_xfer   = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_valid) begin
        w_load      = 1'b1;
        w_load_byte = SOF_BYTE;
      end
      S_ID: begin
        w_load      = 1'b1;
        w_load_byte = 8'(r_grant);
      end
      S_PAYLOAD: if (w_sel_valid) begin
        w_load      = 1'b1;
        w_load_byte = w_sel_data;
        w_up_xfer   = w_slot_free;
      end
      S_CSUM: begin
        w_load      = 1'b1;
        w_load_byte = r_csum;
      end
      default: ;
    endcase
  end

  // Output register, grant/checksum bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_csum       <= '0;
    end else begin
      if (w_slot_free) begin
        r_tx_valid <= w_load;
        if (w_load) r_tx_data <= w_load_byte;
      end
      if (r_state == S_IDLE && w_slot_free && w_any_valid) begin
        r_grant <= w_winner;
        r_csum  <= '0;
      end
      if (w_up_xfer) r_csum <= r_csum ^ w_sel_data;
      if (r_state == S_CSUM && w_slot_free) r_last_grant <= r_grant;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = (r_state != S_IDLE) || r_tx_valid;
  assign bus.grant    = r_grant;
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet scheduler that shares the single `uart_tx` byte transmitter among `NUM_REQ` byte-stream requesters (e.g. convolution result streamer, status/debug reporter). It arbitrates round-robin at packet granularity and frames every packet as SOF, source ID, payload and XOR checksum so the host can demultiplex the serial stream. It sits between the requesters and `uart_tx`, driving the transmitter's `data`/`valid` and consuming its `ready`.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `SOF_BYTE`, default 8'hA5: start-of-frame byte sent before every packet.
- `clk`  in  1  single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_data`  in  8*NUM_REQ  payload byte per requester; requester i uses bits [8i+7:8i].
- `in_valid`  in  NUM_REQ  requester i has a byte on `in_data`.
- `in_last`  in  NUM_REQ  the current byte of requester i ends its packet.
- `in_ready`  out  NUM_REQ  byte of requester i accepted this cycle when `in_valid[i]` is also high.
- `tx_data`  out  8  byte to `uart_tx.data`.
- `tx_valid`  out  1  to `uart_tx.valid`.
- `tx_ready`  in  1  from `uart_tx.ready`.
- `busy`  out  1  high whenever state != IDLE or `tx_valid` is high.
- `grant`  out  $clog2(NUM_REQ)  index of the current or most recent packet owner.

## Operation
- Handshakes: an upstream transfer occurs when `in_valid[i] && in_ready[i]`; a downstream transfer occurs when `tx_valid && tx_ready`.
- Upstream rule: once `in_valid[i]` is high, the requester holds it, `in_data` and `in_last` stable until the transfer.
- Output register: `tx_data`/`tx_valid` are registered and stay stable until the downstream transfer. `slot_free = !tx_valid || tx_ready`.
- The FSM state names the next byte to load; a byte is loaded only when `slot_free`.
- **IDLE**: if any `in_valid` and `slot_free`:
  - Choose the first asserted requester scanning from `last_grant+1` modulo NUM_REQ.
  - Register the winner in `grant`.
  - Load `SOF_BYTE`, clear the checksum to 8'h00, go to **ID**.
  - No payload is accepted in this cycle.
- **ID**: on `slot_free`, load {(8-$clog2(NUM_REQ))'b0, grant} and go to **PAYLOAD**.
- **PAYLOAD**:
  - `in_ready[grant] = slot_free`; all other `in_ready` bits are 0.
  - On an upstream transfer: load `in_data[grant]` and set `csum ^= byte`.
  - If `in_last[grant]` is set on that transfer, go to **CSUM**.
  - Requester bubbles (`in_valid` low) leave `tx_valid` low; grant is held.
- **CSUM**: on `slot_free`, load the accumulated checksum (XOR including the last byte), set `last_grant <= grant`, go to **IDLE**.
- `in_ready` is 0 in every state except PAYLOAD. It is combinational from state, grant and `tx_ready`.
- A packet always carries at least 1 payload byte; there is no length limit.
- Wire framing per packet: SOF, ID, P0..Pn-1, CSUM, i.e. n+3 bytes.
- Changes in `in_valid` from non-granted requesters during a packet have no effect; arbitration is evaluated only in IDLE.

## Timing
- Reset values:
  - `tx_valid`=0, `tx_data`=8'h00, `in_ready`=0, `busy`=0, `grant`=0.
  - state=IDLE, csum=0, `last_grant`=NUM_REQ-1, so requester 0 wins the first contention.
- Request to SOF: `tx_valid` rises the cycle after the first IDLE cycle in which `in_valid` is high and `slot_free` holds.
- The scheduler adds no idle cycles between bytes. Each byte is loaded in the same cycle as the previous byte's downstream handshake, so throughput is limited only by `uart_tx` (about 1 byte per 10 bit times).
- Payload flow-through: `in_ready` is high in the same cycle as `tx_ready` while the slot is occupied, or immediately when the slot is empty.
- CSUM to IDLE: the next SOF load can occur in the same cycle as the CSUM handshake, giving back-to-back packets.
- Reset asserted mid-packet: all registers return to reset values immediately and the partial frame is abandoned. `uart_tx` has its own reset.

## Test plan
- Single packet: requester 0 sends 8'h11, 8'h22, 8'h33 (last) -> `tx_data` sequence A5, 00, 11, 22, 33, 00. Exactly 6 downstream transfers, then `busy`=0.
- Contention: after reset, requesters 0 and 1 raise `in_valid` in the same cycle, each with 2-byte packets -> packet from 0 goes first, then packet from 1 (ID 01). Repeat with both requesters valid -> order alternates 0, 1, 0, 1.
- Grant lock: requester 1 asserts `in_valid` mid-packet of requester 0 -> `in_ready[1]` stays 0 until requester 0's CSUM is loaded. Requester 0's bytes are not interleaved with requester 1's.
- Backpressure and bubbles: model `uart_tx` ready low for 540 cycles after each byte, with requester gaps of 3 cycles -> `tx_data` is stable while valid, no bytes are lost or duplicated, and the checksum is correct.
- Checksum: payload 8'hFF, 8'h0F, 8'hA5 -> CSUM byte 8'h55. Single-byte packet 8'h7E -> frame A5, ID, 7E, 7E.
- Reset mid-payload: assert `rstn`=0 after the ID byte -> `tx_valid`=0 and `in_ready`=0 asynchronously. After release, a new request produces a clean SOF frame with requester 0 priority.
